// File: rtl/pca9685_pkg.sv
// pca9685_pkg: PCA9685 register map, init values, state encodings and byte helpers
package pca9685_pkg;

    localparam logic [7:0] REG_MODE1     = 8'h00;
    localparam logic [7:0] REG_MODE2     = 8'h01;
    localparam logic [7:0] REG_PRESCALE  = 8'hFE;
    localparam logic [7:0] REG_LED0_ON_L = 8'h06;

    localparam logic [7:0] MODE1_SLEEP = 8'h10;
    localparam logic [7:0] MODE1_WAKE  = 8'h00;
    localparam logic [7:0] MODE2_TOTEM = 8'h04;

    typedef enum logic [1:0] {
        SCH_INIT_LOAD,
        SCH_IDLE,
        SCH_LOAD,
        SCH_XFER
    } sch_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ISSUE,
        WR_BACKOFF,
        WR_WAIT_DONE
    } wr_state_e;

    // Register address of init step idx: sleep, prescale, wake, output mode
    function automatic logic [7:0] init_reg(input logic [1:0] idx);
        return (idx == 2'd1) ? REG_PRESCALE : (idx == 2'd3) ? REG_MODE2 : REG_MODE1;
    endfunction

    function automatic logic [7:0] init_val(input logic [1:0] idx, input logic [7:0] prescale);
        return (idx == 2'd0) ? MODE1_SLEEP :
               (idx == 2'd1) ? prescale :
               (idx == 2'd2) ? MODE1_WAKE : MODE2_TOTEM;
    endfunction

    // LEDn_ON_L + byte index; the largest result (ch 15, idx 3) is 0x45
    function automatic logic [7:0] led_reg(input logic [3:0] ch, input logic [1:0] idx);
        return REG_LED0_ON_L + {2'b00, ch, idx};
    endfunction

    function automatic logic [7:0] led_byte(input logic [1:0] idx, input logic [12:0] on,
                                            input logic [12:0] off);
        return (idx == 2'd0) ? on[7:0] :
               (idx == 2'd1) ? {3'b000, on[12:8]} :
               (idx == 2'd2) ? off[7:0] : {3'b000, off[12:8]};
    endfunction

    // First pending channel at or after last+1, wrapping; last itself is checked last
    function automatic logic [3:0] rr_pick(input logic [15:0] pend, input logic [3:0] last);
        logic [3:0] ch;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            ch = last + 4'(i);
            if (!found && pend[ch]) begin
                rr_pick = ch;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/i2c_write_issuer.sv
// i2c_write_issuer: runs one controller write via execute/busy with timeout and retry
module i2c_write_issuer
    import pca9685_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic busy_i,
    output logic execute_o,
    output logic done_o,
    output logic error_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    wr_state_e      state_q, state_d;
    logic [1:0]     sync_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           error_q, error_d;
    logic           busy_s;

    assign busy_s    = sync_q[1];
    assign execute_o = (state_q == WR_ISSUE);
    assign error_o   = error_q;

    // busy comes from the controller's clock domain; bring it in through two flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], busy_i};
    end

    // state, timeout counter and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WR_IDLE;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    // hold execute until busy is seen, back off one cycle on timeout, finish on busy fall
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        error_d = error_q;
        done_o  = 1'b0;
        case (state_q)
            WR_IDLE:      if (start_i) state_d = WR_ISSUE;
            WR_ISSUE: begin
                if (busy_s) begin
                    state_d = WR_WAIT_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = WR_BACKOFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_BACKOFF:   state_d = WR_ISSUE;
            WR_WAIT_DONE: begin
                if (!busy_s) begin
                    done_o  = 1'b1;
                    state_d = WR_IDLE;
                end
            end
            default:      state_d = WR_IDLE;
        endcase
    end

endmodule

// File: rtl/pca9685_update_scheduler.sv
// pca9685_update_scheduler: init sequence then round-robin per-channel ON/OFF writes to a PCA9685
module pca9685_update_scheduler
    import pca9685_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h40,
    parameter logic [7:0] PRESCALE = 8'h79,
    parameter int         TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ch_we_i,
    input  logic [3:0]  ch_id_i,
    input  logic [12:0] ch_on_i,
    input  logic [12:0] ch_off_i,
    output logic [6:0]  address_o,
    output logic        rw_o,
    output logic [7:0]  register_id_o,
    output logic [7:0]  register_value_o,
    output logic        execute_o,
    input  logic        busy_i,
    output logic        init_done_o,
    output logic [15:0] pending_o,
    output logic        error_o
);

    sch_state_e  state_q, state_d;
    logic [1:0]  idx_q, idx_d, idx_nx;
    logic        init_done_q, init_done_d;
    logic [3:0]  sel_q, sel_d, last_q, last_d;
    logic [15:0] pend_q, pend_d;
    logic [12:0] won_q, won_d, woff_q, woff_d;
    logic [7:0]  reg_id_q, reg_id_d, reg_val_q, reg_val_d;
    logic        start_q, start_d;
    logic [12:0] sh_on_q  [16];
    logic [12:0] sh_off_q [16];
    logic        wr_done;

    assign idx_nx           = idx_q + 2'd1;
    assign address_o        = I2C_ADDR;
    assign rw_o             = 1'b0;
    assign register_id_o    = reg_id_q;
    assign register_value_o = reg_val_q;
    assign init_done_o      = init_done_q;
    assign pending_o        = pend_q;

    i2c_write_issuer #(.TIMEOUT(TIMEOUT)) u_issuer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (start_q),
        .busy_i    (busy_i),
        .execute_o (execute_o),
        .done_o    (wr_done),
        .error_o   (error_o)
    );

    // shadow copy of every channel; the latest write simply overwrites
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) begin
                sh_on_q[i]  <= '0;
                sh_off_q[i] <= '0;
            end
        end else if (ch_we_i) begin
            sh_on_q[ch_id_i]  <= ch_on_i;
            sh_off_q[ch_id_i] <= ch_off_i;
        end
    end

    // sequencing state; last starts at 15 so channel 0 is looked at first
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SCH_INIT_LOAD;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            sel_q       <= 4'd0;
            last_q      <= 4'd15;
            pend_q      <= '0;
            won_q       <= '0;
            woff_q      <= '0;
            reg_id_q    <= '0;
            reg_val_q   <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            won_q       <= won_d;
            woff_q      <= woff_d;
            reg_id_q    <= reg_id_d;
            reg_val_q   <= reg_val_d;
            start_q     <= start_d;
        end
    end

    // stage each byte one cycle ahead of its start pulse; a new strobe beats the LOAD clear
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        sel_d       = sel_q;
        last_d      = last_q;
        pend_d      = pend_q;
        won_d       = won_q;
        woff_d      = woff_q;
        reg_id_d    = reg_id_q;
        reg_val_d   = reg_val_q;
        start_d     = 1'b0;
        case (state_q)
            SCH_INIT_LOAD: begin
                reg_id_d  = init_reg(idx_q);
                reg_val_d = init_val(idx_q, PRESCALE);
                start_d   = 1'b1;
                state_d   = SCH_XFER;
            end
            SCH_IDLE: begin
                if (|pend_q) begin
                    sel_d   = rr_pick(pend_q, last_q);
                    state_d = SCH_LOAD;
                end
            end
            SCH_LOAD: begin
                won_d          = sh_on_q[sel_q];
                woff_d         = sh_off_q[sel_q];
                pend_d[sel_q]  = 1'b0;
                last_d         = sel_q;
                idx_d          = 2'd0;
                reg_id_d       = led_reg(sel_q, 2'd0);
                reg_val_d      = led_byte(2'd0, sh_on_q[sel_q], sh_off_q[sel_q]);
                start_d        = 1'b1;
                state_d        = SCH_XFER;
            end
            SCH_XFER: begin
                if (wr_done) begin
                    idx_d = idx_nx;
                    if (!init_done_q) begin
                        init_done_d = (idx_q == 2'd3);
                        state_d     = (idx_q == 2'd3) ? SCH_IDLE : SCH_INIT_LOAD;
                    end else if (idx_q == 2'd3) begin
                        state_d = SCH_IDLE;
                    end else begin
                        reg_id_d  = led_reg(sel_q, idx_nx);
                        reg_val_d = led_byte(idx_nx, won_q, woff_q);
                        start_d   = 1'b1;
                    end
                end
            end
            default: state_d = SCH_INIT_LOAD;
        endcase
        if (ch_we_i) pend_d[ch_id_i] = 1'b1;
    end

endmodule

// File: tb/tb_pca9685_update_scheduler.sv
// tb_pca9685_update_scheduler: controller model plus scoreboard of expected register writes
module tb_pca9685_update_scheduler;

    typedef struct {
        logic [7:0] id;
        logic [7:0] val;
    } txn_t;

    typedef struct {
        logic [3:0]       ch;
        logic [12:0]      on;
        logic [12:0]      off;
        logic [7:0]       id0;
        logic [3:0][7:0]  b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ch_we = 1'b0;
    logic [3:0]  ch_id = '0;
    logic [12:0] ch_on = '0;
    logic [12:0] ch_off = '0;
    logic        busy = 1'b0;
    logic [6:0]  address;
    logic        rw;
    logic [7:0]  reg_id, reg_val;
    logic        execute, init_done, error;
    logic [15:0] pending;

    txn_t obs[$];
    txn_t exp_q[$];
    int   rd = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int   dly = 54;
    int   hold = 1000;
    logic respond = 1'b1;
    int   m_cnt = 0;
    logic m_act = 1'b0;
    logic exe_prev = 1'b0;

    pca9685_update_scheduler dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .ch_we_i          (ch_we),
        .ch_id_i          (ch_id),
        .ch_on_i          (ch_on),
        .ch_off_i         (ch_off),
        .address_o        (address),
        .rw_o             (rw),
        .register_id_o    (reg_id),
        .register_value_o (reg_val),
        .execute_o        (execute),
        .busy_i           (busy),
        .init_done_o      (init_done),
        .pending_o        (pending),
        .error_o          (error)
    );

    always #5 clk = ~clk;

    // controller model: logs each execute rise, answers with busy after dly for hold cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            m_act    = 1'b0;
            busy     = 1'b0;
            exe_prev = 1'b0;
        end else begin
            if (execute && !exe_prev) obs.push_back('{reg_id, reg_val});
            exe_prev = execute;
            if (!m_act && execute && respond) begin
                m_act = 1'b1;
                m_cnt = 0;
            end
            if (m_act) begin
                m_cnt++;
                if (m_cnt == dly) busy = 1'b1;
                if (m_cnt == dly + hold) begin
                    busy  = 1'b0;
                    m_act = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_upd(input int c, input logic [12:0] on, input logic [12:0] off);
        logic [7:0] bytes [4];
        bytes[0] = on[7:0];
        bytes[1] = {3'b000, on[12:8]};
        bytes[2] = off[7:0];
        bytes[3] = {3'b000, off[12:8]};
        for (int i = 0; i < 4; i++) exp_q.push_back('{8'(6 + 4 * c + i), bytes[i]});
    endtask

    task automatic push_init();
        exp_q.push_back('{8'h00, 8'h10});
        exp_q.push_back('{8'hFE, 8'h79});
        exp_q.push_back('{8'h00, 8'h00});
        exp_q.push_back('{8'h01, 8'h04});
    endtask

    task automatic drain(input int n);
        txn_t e;
        int   t = 0;
        while (obs.size() - rd < n && t < 1500 * n) begin
            @(negedge clk);
            t++;
        end
        check("transactions seen", 32'(obs.size() - rd >= n), 1);
        for (int i = 0; i < n; i++) begin
            if (rd >= obs.size() || exp_q.size() == 0) break;
            e = exp_q.pop_front();
            check("register_id", obs[rd].id, e.id);
            check("register_value", obs[rd].val, e.val);
            rd++;
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [12:0] on, input logic [12:0] off);
        @(negedge clk);
        ch_we  = 1'b1;
        ch_id  = c;
        ch_on  = on;
        ch_off = off;
    endtask

    task automatic write_ch(input logic [3:0] c, input logic [12:0] on, input logic [12:0] off);
        drive(c, on, off);
        @(negedge clk);
        ch_we = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vec_t vecs [4];
        int   n;
        vecs[0] = '{ch: 4'd3,  on: 13'h0000, off: 13'h07FF, id0: 8'h12, b: 32'h07FF0000};
        vecs[1] = '{ch: 4'd15, on: 13'h1000, off: 13'h0000, id0: 8'h42, b: 32'h00001000};
        vecs[2] = '{ch: 4'd0,  on: 13'h0ABC, off: 13'h1FFF, id0: 8'h06, b: 32'h1FFF0ABC};
        vecs[3] = '{ch: 4'd9,  on: 13'h0123, off: 13'h0456, id0: 8'h2A, b: 32'h04560123};

        settle(3);
        check("reset execute", execute, 0);
        check("reset register_id", reg_id, 0);
        check("reset register_value", reg_val, 0);
        check("reset init_done", init_done, 0);
        check("reset pending", pending, 0);
        check("reset error", error, 0);
        check("address", address, 7'h40);
        check("rw", rw, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("execute after 1st edge", execute, 0);
        check("init byte staged", reg_val, 8'h10);
        @(negedge clk);
        check("execute after 2nd edge", execute, 1);
        check("init_done during init", init_done, 0);
        push_init();
        drain(4);
        settle(1100);
        check("init_done", init_done, 1);

        dly  = 10;
        hold = 20;
        for (int k = 0; k < 4; k++) begin
            write_ch(vecs[k].ch, vecs[k].on, vecs[k].off);
            check("pending set", pending[vecs[k].ch], 1);
            @(negedge clk);
            check("pending held at pick", pending[vecs[k].ch], 1);
            check("no execute at pick", execute, 0);
            @(negedge clk);
            check("pending cleared at load", pending[vecs[k].ch], 0);
            check("first byte staged", reg_id, vecs[k].id0);
            @(negedge clk);
            check("execute 3 cycles after strobe", execute, 1);
            for (int i = 0; i < 4; i++) exp_q.push_back('{vecs[k].id0 + 8'(i), vecs[k].b[i]});
            drain(4);
            settle(60);
        end

        write_ch(4'd15, 13'h0111, 13'h0222);
        push_upd(15, 13'h0111, 13'h0222);
        settle(3);
        drive(4'd15, 13'h0333, 13'h0444);
        drive(4'd0, 13'h0055, 13'h0066);
        drive(4'd7, 13'h0777, 13'h0888);
        @(negedge clk);
        ch_we = 1'b0;
        check("three pending", pending, 16'h8081);
        push_upd(0, 13'h0055, 13'h0066);
        push_upd(7, 13'h0777, 13'h0888);
        push_upd(15, 13'h0333, 13'h0444);
        drain(9);
        write_ch(4'd0, 13'h0ABC, 13'h0DEF);
        push_upd(0, 13'h0ABC, 13'h0DEF);
        drain(11);
        settle(60);
        check("all served", pending, 0);

        respond = 1'b0;
        write_ch(4'd2, 13'h0055, 13'h00AA);
        exp_q.push_back('{8'h0E, 8'h55});
        push_upd(2, 13'h0055, 13'h00AA);
        for (int t = 0; t < 10 && !execute; t++) @(negedge clk);
        check("execute rise before timeout", execute, 1);
        check("error before timeout", error, 0);
        n = 0;
        while (execute && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("execute high cycles", n, 255);
        check("error after timeout", error, 1);
        @(negedge clk);
        check("retry after one-cycle gap", execute, 1);
        respond = 1'b1;
        drain(5);
        settle(60);
        check("error sticky", error, 1);

        write_ch(4'd4, 13'h00F0, 13'h000F);
        push_upd(4, 13'h00F0, 13'h000F);
        write_ch(4'd9, 13'h0001, 13'h0002);
        drain(2);
        #3;
        check("2nd byte on bus", reg_id, 8'h17);
        check("ch 9 pending before reset", pending[9], 1);
        rst_n = 1'b0;
        #1;
        check("async reset execute", execute, 0);
        check("async reset register_id", reg_id, 0);
        check("async reset register_value", reg_val, 0);
        check("async reset pending", pending, 0);
        check("async reset init_done", init_done, 0);
        check("async reset error", error, 0);
        exp_q.delete();
        settle(2);
        rd = obs.size();
        rst_n = 1'b1;
        push_init();
        drain(4);
        settle(60);
        check("init_done after restart", init_done, 1);
        check("lost updates not served", obs.size() - rd, 0);

        write_ch(4'd5, 13'h0010, 13'h0020);
        write_ch(4'd5, 13'h1030, 13'h0040);
        check("pending re-set during load", pending[5], 1);
        push_upd(5, 13'h0010, 13'h0020);
        push_upd(5, 13'h1030, 13'h0040);
        drain(8);
        settle(60);
        check("ch 5 done", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pca9685_update_scheduler.md
# pca9685_update_scheduler

Sequences the I2C controller to drive a PCA9685 PWM device. After reset it issues a fixed four-write init sequence, then serves per-channel ON/OFF update requests. Channels are picked round-robin; each chosen channel becomes four single-register writes through the controller's execute/busy handshake. It sits between the PWM application logic and the I2C controller, and is the only block that drives that controller.

## Interface
- `I2C_ADDR`, 7'h40: target 7-bit address.
- `PRESCALE`, 8'h79: PRESCALE register value (50 Hz at the 25 MHz device oscillator).
- `TIMEOUT`, 255: cycles to wait for busy to rise after execute before retrying.
- `clk_i`  in  1  system clock; the only clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `ch_we_i`  in  1  update strobe; always accepted.
- `ch_id_i`  in  4  channel 0–15.
- `ch_on_i`  in  13  ON count; bit 12 is full-on.
- `ch_off_i`  in  13  OFF count; bit 12 is full-off.
- `address_o`  out  7  always I2C_ADDR.
- `rw_o`  out  1  always 0 (write).
- `register_id_o`  out  8  register to write.
- `register_value_o`  out  8  byte to write.
- `execute_o`  out  1  transaction request.
- `busy_i`  in  1  controller busy; asynchronous to this logic.
- `init_done_o`  out  1  init sequence complete.
- `pending_o`  out  16  per-channel pending flags.
- `error_o`  out  1  sticky; a timeout has occurred.

## Operation
- `busy_i` passes through a 2-flop synchronizer. All decisions use the synchronized value `busy_s`.
- Shadow storage: 16 × (13b on, 13b off) plus a pending bit per channel.
- `ch_we_i` writes the shadow for `ch_id_i` and sets its pending bit. A later write to the same channel overwrites the shadow; no queueing.
- Init list, issued in this order:
  - MODE1 (0x00) ← 0x10 (sleep)
  - PRESCALE (0xFE) ← PRESCALE
  - MODE1 ← 0x00 (wake)
  - MODE2 (0x01) ← 0x04 (totem-pole)
- States:
  - INIT_LOAD: put the next init byte on the outputs, then go to ISSUE.
  - IDLE: if any channel is pending, pick the first one at or after `last+1` (mod 16) and go to LOAD. Otherwise stay.
  - LOAD: snapshot that channel's shadow into a working register, clear its pending bit, set `idx` = 0, go to ISSUE.
  - ISSUE: assert `execute_o`. When `busy_s` = 1, go to WAIT_DONE. If `TIMEOUT` cycles pass first, set `error_o` and go to BACKOFF.
  - BACKOFF: deassert `execute_o` for one cycle, then return to ISSUE and retry the same byte.
  - WAIT_DONE: `execute_o` = 0. When `busy_s` = 0, advance `idx`:
    - during init: after the 4th write set `init_done_o` and go to IDLE, otherwise go to INIT_LOAD;
    - during an update: after `idx` = 3 go to IDLE, otherwise go back to ISSUE.
- Update writes: `register_id_o` = 0x06 + 4·ch + `idx`. Bytes in `idx` order:
  - ON_L = on[7:0]
  - ON_H = {3'b0, on[12:8]}
  - OFF_L = off[7:0]
  - OFF_H = {3'b0, off[12:8]}
- Address arithmetic is 8-bit with no overflow; the maximum is 0x45.
- Same-cycle write to the channel being loaded: LOAD snapshots the old value, and the pending bit ends up set again (the set wins over the clear).
- Updates received during init are held as pending and served after `init_done_o`.

## Timing
- Reset values:
  - `execute_o` = 0, `register_id_o` = 0, `register_value_o` = 0, `init_done_o` = 0, `pending_o` = 0, `error_o` = 0.
  - Shadows = 0; `last` = 15, so channel 0 is checked first.
- After reset deassertion, the first `execute_o` rises on the 2nd rising edge (INIT_LOAD → ISSUE).
- `register_id_o` and `register_value_o` are registered. They are stable from one cycle before `execute_o` rises until WAIT_DONE exits.
- `execute_o` is held until `busy_s` rises. This is required because the controller samples execute only on its slow-clock edge.
- Reset mid-transaction: all state clears immediately and init restarts from MODE1. Outstanding pending updates are lost.
- From update strobe (scheduler idle) to first `execute_o`: 3 cycles (shadow write, IDLE pick, LOAD).

## Structure
- Shared package `pca9685_pkg` holds:
  - register constants MODE1, MODE2, PRESCALE, LED0_ON_L (0x06);
  - MODE values 0x10, 0x00, 0x04;
  - the state encoding constants.
- Sub-module `i2c_write_issuer` contains the busy synchronizer, ISSUE/BACKOFF/WAIT_DONE, and the timeout counter. Its interface is `start`/`done` plus `error`.
- The top level holds the shadows, the round-robin picker, the init ROM, and byte sequencing.

## Test plan
- Reset release, controller model asserts busy 54 cycles after execute and holds it 1000 cycles → 4 writes: (0x00,0x10), (0xFE,0x79), (0x00,0x00), (0x01,0x04); then `init_done_o` = 1.
- After init, write ch 3 on = 0x000, off = 0x7FF → writes (0x12,0x00), (0x13,0x00), (0x14,0xFF), (0x15,0x07); `pending_o[3]` clears at LOAD.
- Write ch 15, 0, 7 in consecutive cycles while idle → service order 0, 7, 15. Re-writing ch 0 while ch 7 is transmitting → ch 0 served again after ch 15.
- Controller model never asserts busy → `error_o` = 1 after 255 cycles; one-cycle `execute_o` low gap, then retry of the same register.
- Pull `rst_ni` low during the 2nd update byte → outputs go to reset values asynchronously; after release, init restarts with (0x00,0x10).
- Write ch 5 in the same cycle LOAD selects ch 5 → old value transmitted, `pending_o[5]` = 1 afterwards, new value sent next.
